// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-source FIFOs for CSR, LSU and ALU results, drained onto
// the single GPR write port with CSR > LSU > ALU priority.

module wb_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [ADDR_WIDTH-1:0]      push_addr,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [ADDR_WIDTH-1:0]      head_addr,
  output logic [DATA_WIDTH-1:0]      head_data,
  output logic [(1<<ADDR_WIDTH)-1:0] pend
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         wptr;
  logic [CW-1:0]         cnt;
  logic [PW-1:0]         off;

  assign full      = (cnt == CW'(FIFO_DEPTH));
  assign empty     = (cnt == '0);
  assign head_addr = mem_addr[rptr];
  assign head_data = mem_data[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem_addr[wptr] <= push_addr;
        mem_data[wptr] <= push_data;
        wptr           <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    pend = '0;
    off  = '0;
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      off = PW'(j) - rptr;
      if ({1'b0, off} < cnt) pend[mem_addr[j]] = 1'b1;
    end
  end
endmodule

module wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       csr_wb_vld,
  input  logic [DATA_WIDTH-1:0]      csr_wb_data,
  input  logic [ADDR_WIDTH-1:0]      csr_wb_addr,
  input  logic                       lsu_wb_vld,
  output logic                       lsu_wb_rdy,
  input  logic [DATA_WIDTH-1:0]      lsu_wb_data,
  input  logic [ADDR_WIDTH-1:0]      lsu_wb_addr,
  input  logic                       alu_wb_vld,
  output logic                       alu_wb_rdy,
  input  logic [DATA_WIDTH-1:0]      alu_wb_data,
  input  logic [ADDR_WIDTH-1:0]      alu_wb_addr,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic [(1<<ADDR_WIDTH)-1:0] pend_mask,
  output logic                       busy,
  output logic                       ovf_err
);
  localparam int NR = 1 << ADDR_WIDTH;

  logic csr_full, csr_empty, csr_push, csr_pop;
  logic lsu_full, lsu_empty, lsu_push, lsu_pop;
  logic alu_full, alu_empty, alu_push, alu_pop;
  logic [ADDR_WIDTH-1:0] csr_haddr, lsu_haddr, alu_haddr;
  logic [DATA_WIDTH-1:0] csr_hdata, lsu_hdata, alu_hdata;
  logic [NR-1:0]         csr_pend, lsu_pend, alu_pend, pend_all;

  assign lsu_wb_rdy = ~lsu_full;
  assign alu_wb_rdy = ~alu_full;

  // x0 results complete the handshake but are never buffered.
  assign csr_push = csr_wb_vld & ~csr_full   & (csr_wb_addr != '0);
  assign lsu_push = lsu_wb_vld & lsu_wb_rdy  & (lsu_wb_addr != '0);
  assign alu_push = alu_wb_vld & alu_wb_rdy  & (alu_wb_addr != '0);

  assign csr_pop  = ~csr_empty;
  assign lsu_pop  = csr_empty & ~lsu_empty;
  assign alu_pop  = csr_empty & lsu_empty & ~alu_empty;

  wb_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_csr (
    .clk(clk), .rst_n(rst_n), .push(csr_push), .push_addr(csr_wb_addr), .push_data(csr_wb_data),
    .pop(csr_pop), .full(csr_full), .empty(csr_empty), .head_addr(csr_haddr),
    .head_data(csr_hdata), .pend(csr_pend));

  wb_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_lsu (
    .clk(clk), .rst_n(rst_n), .push(lsu_push), .push_addr(lsu_wb_addr), .push_data(lsu_wb_data),
    .pop(lsu_pop), .full(lsu_full), .empty(lsu_empty), .head_addr(lsu_haddr),
    .head_data(lsu_hdata), .pend(lsu_pend));

  wb_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_alu (
    .clk(clk), .rst_n(rst_n), .push(alu_push), .push_addr(alu_wb_addr), .push_data(alu_wb_data),
    .pop(alu_pop), .full(alu_full), .empty(alu_empty), .head_addr(alu_haddr),
    .head_data(alu_hdata), .pend(alu_pend));

  assign pend_all  = csr_pend | lsu_pend | alu_pend;
  assign pend_mask = {pend_all[NR-1:1], 1'b0};
  assign busy      = ~(csr_empty & lsu_empty & alu_empty);

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (csr_pop) begin
      rf_wen = 1'b1; rf_waddr = csr_haddr; rf_wdata = csr_hdata;
    end else if (lsu_pop) begin
      rf_wen = 1'b1; rf_waddr = lsu_haddr; rf_wdata = lsu_hdata;
    end else if (alu_pop) begin
      rf_wen = 1'b1; rf_waddr = alu_haddr; rf_wdata = alu_hdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                      ovf_err <= 1'b0;
    else if (csr_wb_vld && csr_full) ovf_err <= 1'b1;
  end
endmodule
